// File: rtl/life_grid_dbuf_mem_if.sv
// Bundle of the control, read, write and swap signals of the double-buffered Life grid.
// The widths follow the memory that sits on the slave side: COLS data bits and ADDR_W row-address bits.
// master = engine/renderer/controller side, slave = memory side.
interface life_grid_dbuf_mem_if #(
  parameter int COLS   = 16,
  parameter int ADDR_W = 2
);
  logic              init_req;
  logic              init_mode;
  logic              busy;
  logic [ADDR_W-1:0] vga_row;
  logic [COLS-1:0]   vga_data;
  logic [ADDR_W-1:0] eng_rd_row;
  logic [COLS-1:0]   eng_rd_data;
  logic              eng_wr_en;
  logic [ADDR_W-1:0] eng_wr_row;
  logic [COLS-1:0]   eng_wr_data;
  logic              swap_req;
  logic              swap_ack;
  logic              front_sel;

  modport master (
    output init_req, init_mode, vga_row, eng_rd_row,
           eng_wr_en, eng_wr_row, eng_wr_data, swap_req,
    input  busy, vga_data, eng_rd_data, swap_ack, front_sel
  );

  modport slave (
    input  init_req, init_mode, vga_row, eng_rd_row,
           eng_wr_en, eng_wr_row, eng_wr_data, swap_req,
    output busy, vga_data, eng_rd_data, swap_ack, front_sel
  );
endinterface

// File: rtl/life_grid_dbuf_mem.sv
// Double-buffered ROWS x COLS cell memory: front bank read by VGA and engine, back bank written by the engine.
// Latency: both read ports 1 cycle; swap_ack 1 cycle after the swap edge; init takes exactly ROWS cycles.
// No backpressure: writes and reads while busy are dropped/return 0, a swap requested while busy is held pending.
module life_grid_dbuf_mem #(
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  life_grid_dbuf_mem_if.slave bus
);

  // Banks are sized to the full address space so any row address indexes safely;
  // rows at or above ROWS are never written or read.
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   ROWS_LIM = (ADDR_W + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [COLS-1:0]   PAT_EVEN = {(COLS / 2){2'b10}};
  localparam logic [COLS-1:0]   PAT_ODD  = {(COLS / 2){2'b01}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_INIT = 1'b1;

  logic [COLS-1:0]   bank_a [DEPTH];
  logic [COLS-1:0]   bank_b [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              mode;
  logic              front_sel_q;
  logic              swap_ack_q;
  logic              swap_pend;
  logic [COLS-1:0]   vga_q;
  logic [COLS-1:0]   eng_q;

  logic              busy;
  logic              init_last;
  logic              wr_ok;
  logic              do_swap;
  logic              vga_in_range;
  logic              eng_in_range;
  logic [COLS-1:0]   init_pat;
  logic [COLS-1:0]   vga_front;
  logic [COLS-1:0]   eng_front;

  assign busy         = (state == ST_INIT);
  assign init_last    = busy && (cnt == LAST_ROW);
  assign wr_ok        = bus.eng_wr_en && !busy && ({1'b0, bus.eng_wr_row} < ROWS_LIM);
  assign vga_in_range = ({1'b0, bus.vga_row} < ROWS_LIM);
  assign eng_in_range = ({1'b0, bus.eng_rd_row} < ROWS_LIM);
  // A request on the final init edge merges with any pending one and completes with it.
  assign do_swap      = (bus.swap_req && !busy) || (init_last && (swap_pend || bus.swap_req));

  // Pattern row for the init sequencer: all zeros, or alternating checkerboard rows.
  always_comb begin
    init_pat = '0;
    if (mode) begin
      init_pat = cnt[0] ? PAT_ODD : PAT_EVEN;
    end
  end

  // Front-bank row lookup for both read ports.
  always_comb begin
    vga_front = front_sel_q ? bank_b[bus.vga_row]    : bank_a[bus.vga_row];
    eng_front = front_sel_q ? bank_b[bus.eng_rd_row] : bank_a[bus.eng_rd_row];
  end

  // IDLE/INIT sequencer: reset always restarts a clear from row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
            mode  <= bus.init_mode;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (init_last) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Bank A: init writes every row; the engine writes here only while B is in front.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        bank_a[cnt] <= init_pat;
      end else if (wr_ok && front_sel_q) begin
        bank_a[bus.eng_wr_row] <= bus.eng_wr_data;
      end
    end
  end

  // Bank B: init writes every row; the engine writes here only while A is in front.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        bank_b[cnt] <= init_pat;
      end else if (wr_ok && !front_sel_q) begin
        bank_b[bus.eng_wr_row] <= bus.eng_wr_data;
      end
    end
  end

  // Swap control: immediate toggle when idle, otherwise deferred to the end of init.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      swap_pend   <= 1'b0;
    end else begin
      swap_ack_q <= do_swap;
      if (do_swap) begin
        front_sel_q <= ~front_sel_q;
        swap_pend   <= 1'b0;
      end else if (busy && bus.swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

  // Registered read ports; the pre-edge front_sel picks the bank, so a read at a swap edge sees the old front.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_q <= '0;
      eng_q <= '0;
    end else begin
      vga_q <= (!busy && vga_in_range) ? vga_front : '0;
      eng_q <= (!busy && eng_in_range) ? eng_front : '0;
    end
  end

  assign bus.busy        = busy;
  assign bus.vga_data    = vga_q;
  assign bus.eng_rd_data = eng_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.front_sel   = front_sel_q;

endmodule

// File: tb/tb_life_grid_dbuf_mem.sv
// Directed, table-driven bench for life_grid_dbuf_mem (COLS=16, ROWS=4, ADDR_W=3).
// Each record holds the inputs applied before one rising edge and the outputs expected just after it.
// A short hand-written sequence measures the init busy window with a bounded wait.
module tb_life_grid_dbuf_mem;

  logic clk;
  logic reset;

  life_grid_dbuf_mem_if #(.COLS(16), .ADDR_W(3)) bus ();

  life_grid_dbuf_mem #(.COLS(16), .ROWS(4), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        imode;
    logic [2:0]  vrow;
    logic [2:0]  erow;
    logic        we;
    logic [2:0]  wrow;
    logic [15:0] wdat;
    logic        sreq;
    logic        busy;
    logic        fs;
    logic        ack;
    logic [15:0] vga;
    logic [15:0] eng;
  } vec_t;

  vec_t vq[$];
  int   tests;
  int   fails;

  task automatic add(input logic rst, input logic ireq, input logic imode,
                     input logic [2:0] vrow, input logic [2:0] erow,
                     input logic we, input logic [2:0] wrow, input logic [15:0] wdat,
                     input logic sreq, input logic busy, input logic fs, input logic ack,
                     input logic [15:0] vga, input logic [15:0] eng);
    vec_t t;
    t.rst = rst; t.ireq = ireq; t.imode = imode; t.vrow = vrow; t.erow = erow;
    t.we = we; t.wrow = wrow; t.wdat = wdat; t.sreq = sreq;
    t.busy = busy; t.fs = fs; t.ack = ack; t.vga = vga; t.eng = eng;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset           = 1'b0;
    bus.init_req    = 1'b0;
    bus.init_mode   = 1'b0;
    bus.vga_row     = '0;
    bus.eng_rd_row  = '0;
    bus.eng_wr_en   = 1'b0;
    bus.eng_wr_row  = '0;
    bus.eng_wr_data = '0;
    bus.swap_req    = 1'b0;
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    idle_inputs();

    //   rst ireq imode vrow erow we wrow wdat     sreq | busy fs ack vga      eng
    // reset, then 4-cycle clear
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 2, 3, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    // checkerboard init; a second init_req while busy is ignored
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0,   0, 0, 0, 16'hAAAA, 16'h5555);
    add(0, 0, 0, 3, 2, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h5555, 16'hAAAA);
    // write back row 2, front unchanged; then swap exposes it
    add(0, 0, 0, 2, 2, 1, 2, 16'h1234, 0,   0, 0, 0, 16'hAAAA, 16'hAAAA);
    add(0, 0, 0, 2, 2, 0, 0, 16'h0000, 0,   0, 0, 0, 16'hAAAA, 16'hAAAA);
    add(0, 0, 0, 2, 2, 0, 0, 16'h0000, 1,   0, 1, 1, 16'hAAAA, 16'hAAAA);
    add(0, 0, 0, 2, 0, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h1234, 16'hAAAA);
    add(0, 0, 0, 1, 3, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h5555, 16'h5555);
    // swap and write on the same edge
    add(0, 0, 0, 1, 1, 1, 1, 16'hF00F, 1,   0, 0, 1, 16'h5555, 16'h5555);
    add(0, 0, 0, 1, 2, 0, 0, 16'h0000, 0,   0, 0, 0, 16'hF00F, 16'hAAAA);
    // clear init with two merged swap requests while busy
    add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'hAAAA, 16'hAAAA);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   0, 1, 1, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 2, 3, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h0000, 16'h0000);
    // reset in the 2nd cycle of a checkerboard init with a swap pending
    add(0, 1, 1, 0, 0, 0, 0, 16'h0000, 0,   1, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1,   1, 1, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 1, 3, 16'hFFFF, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,   1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 2, 3, 0, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000);
    // out-of-range write and read, then swap to inspect the other bank
    add(0, 0, 0, 5, 5, 1, 5, 16'hBEEF, 0,   0, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 3, 0, 0, 16'h0000, 1,   0, 1, 1, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 5, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 3, 2, 0, 0, 16'h0000, 0,   0, 1, 0, 16'h0000, 16'h0000);

    foreach (vq[i]) begin
      @(negedge clk);
      reset           = vq[i].rst;
      bus.init_req    = vq[i].ireq;
      bus.init_mode   = vq[i].imode;
      bus.vga_row     = vq[i].vrow;
      bus.eng_rd_row  = vq[i].erow;
      bus.eng_wr_en   = vq[i].we;
      bus.eng_wr_row  = vq[i].wrow;
      bus.eng_wr_data = vq[i].wdat;
      bus.swap_req    = vq[i].sreq;
      @(posedge clk);
      #1;
      chk("busy",        i, {15'd0, bus.busy},      {15'd0, vq[i].busy});
      chk("front_sel",   i, {15'd0, bus.front_sel}, {15'd0, vq[i].fs});
      chk("swap_ack",    i, {15'd0, bus.swap_ack},  {15'd0, vq[i].ack});
      chk("vga_data",    i, bus.vga_data,           vq[i].vga);
      chk("eng_rd_data", i, bus.eng_rd_data,        vq[i].eng);
    end

    // Hand-written: checkerboard init from idle, busy window measured with a bounded wait.
    @(negedge clk);
    idle_inputs();
    bus.init_req  = 1'b1;
    bus.init_mode = 1'b1;
    @(negedge clk);
    bus.init_req  = 1'b0;
    bus.init_mode = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      n++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 100, 16'(n), 16'd4);
    chk("swap_ack_after_init", 101, {15'd0, bus.swap_ack}, 16'd0);
    bus.vga_row    = 3'd3;
    bus.eng_rd_row = 3'd0;
    @(negedge clk);
    chk("vga_row3_checker", 102, bus.vga_data,    16'h5555);
    chk("eng_row0_checker", 103, bus.eng_rd_data, 16'hAAAA);
    chk("front_sel_kept",   104, {15'd0, bus.front_sel}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/life_grid_dbuf_mem.md
Name: life_grid_dbuf_mem

Overview:
- Parametrised, double-buffered cell-state memory for the Life engine: two banks of ROWS x COLS alive bits.
- The front bank feeds the VGA renderer and the engine's read port. The engine writes the next generation into the back bank.
- A swap handshake flips the banks between generations.
- A built-in init sequencer clears the grid or loads a test pattern, one row per cycle.

Parameters:
- COLS, 16, cells per row (data width of every data port).
- ROWS, 4, number of rows per bank.
- ADDR_W, 2, row-address width. Requirement: ROWS <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- init_req  in  1  one-cycle request to start an init sequence
- init_mode  in  1  pattern select, sampled with init_req: 0 = clear, 1 = checkerboard
- busy  out  1  init sequence in progress
- vga_row  in  ADDR_W  VGA read row address
- vga_data  out  COLS  front-bank row data for vga_row
- eng_rd_row  in  ADDR_W  engine read row address
- eng_rd_data  out  COLS  front-bank row data for eng_rd_row
- eng_wr_en  in  1  engine write strobe, targets the back bank
- eng_wr_row  in  ADDR_W  engine write row address
- eng_wr_data  in  COLS  engine write data
- swap_req  in  1  one-cycle request to exchange front and back banks
- swap_ack  out  1  one-cycle pulse confirming the swap
- front_sel  out  1  current front bank: 0 = bank A, 1 = bank B

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high.
- Reset values: front_sel=0, swap_ack=0, vga_data=0, eng_rd_data=0, swap pending flag cleared, busy=1.
  - Reset forces the state machine into INIT with mode=clear and row counter=0.
  - Reset during an active init restarts the clear from row 0.
- State machine IDLE/INIT.
  - IDLE -> INIT on init_req; init_mode is latched at that edge.
  - In INIT, every edge writes row[cnt] of both banks with the pattern, then increments cnt.
  - On the edge that writes row ROWS-1, the machine returns to IDLE, so busy is high for exactly ROWS cycles.
  - init_req while busy is ignored.
- Patterns:
  - clear: all zeros.
  - checkerboard: even rows = {COLS/2{2'b10}}, odd rows = {COLS/2{2'b01}}. COLS is even.
- Reads: both read ports are fully independent and registered, latency 1.
  - data(t+1) = front[row(t)].
  - A row >= ROWS returns 0.
  - While busy, both ports return 0.
- Writes: on an edge with eng_wr_en=1, busy=0 and eng_wr_row < ROWS, back[eng_wr_row] <= eng_wr_data.
  - All other writes are dropped silently.
  - An engine write can never modify the front bank.
- Swap:
  - If swap_req=1 and busy=0 at an edge, front_sel toggles at that edge and swap_ack=1 for the following cycle, coinciding with the new front_sel.
  - If swap_req arrives while busy, it is recorded in a pending flag. It executes on the edge that returns INIT -> IDLE, with swap_ack following as above.
  - Further requests while a swap is pending merge into that one swap.
  - Reset clears the pending flag.
- Same-edge swap and write: the write goes to the back bank selected by the pre-edge front_sel. The written row is therefore visible in the new front bank.
- Same-edge read and swap: a read sampled at the swap edge returns data from the pre-swap front bank. The next read returns data from the new front bank.
- Same-edge read and write to the same row: no interaction, since the two ports address different banks.

Test Plan:
- Pulse reset 1 cycle (COLS=16, ROWS=4) -> busy=1 for 4 cycles then 0; front_sel=0; reading rows 0..3 on both ports gives 0x0000.
- init_req with init_mode=1 -> busy for 4 cycles; then vga_row=0 gives 0xAAAA and eng_rd_row=1 gives 0x5555, each 1 cycle after the address; row 3 gives 0x5555.
- Write row 2 = 0x1234, then read row 2 -> still 0xAAAA. Pulse swap_req -> front_sel=1 and swap_ack for 1 cycle; row 2 then reads 0x1234, rows 0/1/3 read 0xAAAA/0x5555/0x5555.
- swap_req and eng_wr_en (row 1, 0xF00F) on the same edge -> front_sel toggles; row 1 then reads 0xF00F from the new front bank.
- swap_req during init (mode 0) -> no ack while busy; front_sel toggles on the INIT -> IDLE edge, swap_ack the cycle after; all rows read 0x0000.
- reset asserted in the 2nd cycle of a checkerboard init with a swap pending -> busy restarts for 4 cycles; no swap_ack; front_sel=0; all rows read 0x0000. Writes to row 3 with ADDR_W=3 and row 5 are dropped, and reads of row 5 give 0.
